// File: rtl/soc_system_sysid_checker.sv
// soc_system_sysid_checker
//   Avalon-MM read master. After reset (when AUTO_START is set) or on request,
//   it reads the system-ID slave: word 0 is the ID and word 1 is the build
//   timestamp. It compares both words against the build-time constants and
//   raises a sticky verdict. A mismatch is re-read up to MAX_RETRY times. Each
//   transaction has a cycle budget of TIMEOUT cycles, counted from read issue
//   to data capture.
//
// Ports
//   clock, reset_n       system clock, asynchronous active-low reset
//   start                level-sampled check request, ignored while busy
//   avm_address/avm_read registered word address and read strobe
//   avm_waitrequest      slave stall
//   avm_readdata         slave read data
//   id_value/ts_value    last captured ID / timestamp words
//   busy                 check in progress
//   done/match           sticky completion / pass verdict
//   error_timeout        sticky: the last check timed out
module soc_system_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID  = 32'hACD51314,
  parameter logic [31:0] EXPECTED_TS  = 32'h594D7BAE,
  parameter bit          CHECK_TS     = 1'b1,
  parameter int          READ_LATENCY = 0,
  parameter int          TIMEOUT      = 255,
  parameter int          MAX_RETRY    = 2,
  parameter bit          AUTO_START   = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic        busy,
  output logic        done,
  output logic        match,
  output logic        error_timeout
);

  localparam int            AW        = $clog2(MAX_RETRY + 1) + 1;
  localparam logic [15:0]   TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [1:0]    LAT_LAST  = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic [AW-1:0] RETRY_MAX = AW'(MAX_RETRY);

  typedef enum logic [2:0] {
    IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, COMPARE, FINISH
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_first;
  logic            r_read, w_read_nxt;
  logic            r_addr, w_addr_nxt;
  logic [31:0]     r_id, w_id_nxt;
  logic [31:0]     r_ts, w_ts_nxt;
  logic            r_busy;
  logic            r_done, w_done_nxt;
  logic            r_match, w_match_nxt;
  logic            r_err, w_err_nxt;
  logic [AW-1:0]   r_attempt, w_attempt_nxt;
  logic [15:0]     r_to_cnt, w_to_nxt;
  logic [1:0]      r_lat_cnt, w_lat_nxt;

  logic            w_accept;
  logic            w_to_hit;
  logic            w_pass;
  logic            w_start;

  assign w_accept = r_read && !avm_waitrequest;
  // >= rather than ==: with latency the count can pass TO_LAST during LAT_*.
  assign w_to_hit = (r_to_cnt >= TO_LAST);
  assign w_pass   = (r_id == EXPECTED_ID) && (!CHECK_TS || (r_ts == EXPECTED_TS));
  // r_first is high only in the first cycle after reset release.
  assign w_start  = start || (AUTO_START && r_first);

  always_comb begin
    w_state_nxt   = r_state;
    w_read_nxt    = r_read;
    w_addr_nxt    = r_addr;
    w_id_nxt      = r_id;
    w_ts_nxt      = r_ts;
    w_done_nxt    = r_done;
    w_match_nxt   = r_match;
    w_err_nxt     = r_err;
    w_attempt_nxt = r_attempt;
    w_to_nxt      = r_to_cnt;
    w_lat_nxt     = r_lat_cnt;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt   = RD_ID;
          w_read_nxt    = 1'b1;
          w_addr_nxt    = 1'b0;
          w_done_nxt    = 1'b0;
          w_match_nxt   = 1'b0;
          w_err_nxt     = 1'b0;
          w_attempt_nxt = '0;
          w_to_nxt      = '0;
        end
      end
      RD_ID, RD_TS: begin
        w_to_nxt = r_to_cnt + 16'd1;
        if (w_accept) begin
          if (READ_LATENCY == 0) begin
            if (r_state == RD_ID) begin
              w_id_nxt    = avm_readdata;
              w_state_nxt = RD_TS;
              w_addr_nxt  = 1'b1;
              w_to_nxt    = '0;
            end else begin
              w_ts_nxt    = avm_readdata;
              w_state_nxt = COMPARE;
              w_read_nxt  = 1'b0;
            end
          end else begin
            w_read_nxt  = 1'b0;
            w_lat_nxt   = '0;
            w_state_nxt = (r_state == RD_ID) ? LAT_ID : LAT_TS;
          end
        end else if (w_to_hit) begin
          w_read_nxt  = 1'b0;
          w_err_nxt   = 1'b1;
          w_match_nxt = 1'b0;
          w_state_nxt = FINISH;
        end
      end
      LAT_ID, LAT_TS: begin
        w_to_nxt  = r_to_cnt + 16'd1;
        w_lat_nxt = r_lat_cnt + 2'd1;
        if (r_lat_cnt == LAT_LAST) begin
          if (r_state == LAT_ID) begin
            w_id_nxt    = avm_readdata;
            w_state_nxt = RD_TS;
            w_read_nxt  = 1'b1;
            w_addr_nxt  = 1'b1;
            w_to_nxt    = '0;
          end else begin
            w_ts_nxt    = avm_readdata;
            w_state_nxt = COMPARE;
          end
        end else if (w_to_hit) begin
          w_err_nxt   = 1'b1;
          w_match_nxt = 1'b0;
          w_state_nxt = FINISH;
        end
      end
      COMPARE: begin
        if (w_pass) begin
          w_match_nxt = 1'b1;
          w_state_nxt = FINISH;
        end else if (r_attempt < RETRY_MAX) begin
          w_attempt_nxt = r_attempt + AW'(1);
          w_state_nxt   = RD_ID;
          w_read_nxt    = 1'b1;
          w_addr_nxt    = 1'b0;
          w_to_nxt      = '0;
        end else begin
          w_match_nxt = 1'b0;
          w_state_nxt = FINISH;
        end
      end
      FINISH: begin
        w_done_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_first <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_first <= 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_read    <= 1'b0;
      r_addr    <= 1'b0;
      r_id      <= '0;
      r_ts      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_match   <= 1'b0;
      r_err     <= 1'b0;
      r_attempt <= '0;
      r_to_cnt  <= '0;
      r_lat_cnt <= '0;
    end else begin
      r_read    <= w_read_nxt;
      r_addr    <= w_addr_nxt;
      r_id      <= w_id_nxt;
      r_ts      <= w_ts_nxt;
      r_busy    <= (w_state_nxt != IDLE);
      r_done    <= w_done_nxt;
      r_match   <= w_match_nxt;
      r_err     <= w_err_nxt;
      r_attempt <= w_attempt_nxt;
      r_to_cnt  <= w_to_nxt;
      r_lat_cnt <= w_lat_nxt;
    end
  end

  assign avm_read      = r_read;
  assign avm_address   = r_addr;
  assign id_value      = r_id;
  assign ts_value      = r_ts;
  assign busy          = r_busy;
  assign done          = r_done;
  assign match         = r_match;
  assign error_timeout = r_err;

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
`timescale 1ns/1ps
module tb_soc_system_sysid_checker;

  localparam logic [31:0] EID = 32'hACD51314;
  localparam logic [31:0] ETS = 32'h594D7BAE;
  localparam int          T   = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT0: default build. DUT1: latency 2, timestamp not checked, one retry.
  logic        rst0_n, start0, wait0, addr0, read0, busy0, done0, match0, err0;
  logic [31:0] rdata0, id0, ts0;
  logic        rst1_n, start1, wait1, addr1, read1, busy1, done1, match1, err1;
  logic [31:0] rdata1, id1, ts1;

  soc_system_sysid_checker u_dut0 (
    .clock(clk), .reset_n(rst0_n), .start(start0),
    .avm_address(addr0), .avm_read(read0), .avm_waitrequest(wait0),
    .avm_readdata(rdata0), .id_value(id0), .ts_value(ts0),
    .busy(busy0), .done(done0), .match(match0), .error_timeout(err0)
  );

  soc_system_sysid_checker #(
    .CHECK_TS(1'b0), .READ_LATENCY(2), .MAX_RETRY(1), .AUTO_START(1'b0)
  ) u_dut1 (
    .clock(clk), .reset_n(rst1_n), .start(start1),
    .avm_address(addr1), .avm_read(read1), .avm_waitrequest(wait1),
    .avm_readdata(rdata1), .id_value(id1), .ts_value(ts1),
    .busy(busy1), .done(done1), .match(match1), .error_timeout(err1)
  );

  int          cur;
  logic        c_read, c_addr, c_busy, c_done, c_match, c_err;
  logic [31:0] c_id, c_ts;
  assign c_read  = (cur == 0) ? read0  : read1;
  assign c_addr  = (cur == 0) ? addr0  : addr1;
  assign c_busy  = (cur == 0) ? busy0  : busy1;
  assign c_done  = (cur == 0) ? done0  : done1;
  assign c_match = (cur == 0) ? match0 : match1;
  assign c_err   = (cur == 0) ? err0   : err1;
  assign c_id    = (cur == 0) ? id0    : id1;
  assign c_ts    = (cur == 0) ? ts0    : ts1;

  int          n_vec = 0;
  int          n_bad = 0;
  int          p_stall [8];
  logic [31:0] p_data  [8];
  logic [31:0] m_id    [2];
  logic [31:0] m_ts    [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL dut%0d %s: observed %0h expected %0h (t=%0t)", cur, tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic st, input logic w, input logic [31:0] d);
    if (cur == 0) begin start0 = st; wait0 = w; rdata0 = d; end
    else          begin start1 = st; wait1 = w; rdata1 = d; end
  endtask

  task automatic set_rst(input logic v);
    if (cur == 0) rst0_n = v; else rst1_n = v;
  endtask

  task automatic plan_clean();
    for (int i = 0; i < 8; i++) begin
      p_stall[i] = 0;
      p_data[i]  = (i % 2 == 0) ? EID : ETS;
    end
  endtask

  task automatic plan_random(input int maxstall);
    for (int i = 0; i < 8; i++) begin
      p_stall[i] = $urandom_range(0, maxstall);
      if (i % 2 == 0) p_data[i] = ($urandom_range(0, 3) != 0) ? EID : $urandom;
      else            p_data[i] = ($urandom_range(0, 2) != 0) ? ETS :
                                  (($urandom_range(0, 1) != 0) ? 32'h0 : $urandom);
    end
    if ($urandom_range(0, 7) == 0) p_stall[$urandom_range(0, 5)] = T + $urandom_range(0, 3);
  endtask

  // Entered at a falling edge (cycle N). kick=0 means the reset was just released
  // and the check is expected to auto-start.
  task automatic run_check(input bit kick, input bit poke, input bit abort);
    int          L, MR, e_D, e_reads, idx, poke_c, k, stall_left, lat_cnt;
    int          addr_err, done_c, ts_acc_c, extra;
    bit          cts, e_pass, e_to, in_txn;
    logic        txn_addr, w;
    logic [31:0] e_id, e_ts, hold, d;
    L   = (cur == 0) ? 0 : 2;
    MR  = (cur == 0) ? 2 : 1;
    cts = (cur == 0);
    // Reference: cycle cost of each transaction and verdict from the read plan.
    e_D = 1; e_reads = 0; idx = 0; e_pass = 0; e_to = 0;
    e_id = m_id[cur]; e_ts = m_ts[cur];
    for (int att = 0; att <= MR && !e_pass && !e_to; att++) begin
      for (int wd = 0; wd < 2 && !e_to; wd++) begin
        if (p_stall[idx] >= T) begin
          e_D += T;
          e_to = 1;
        end else begin
          e_D += p_stall[idx] + 1 + L;
          if (wd == 0) e_id = p_data[idx]; else e_ts = p_data[idx];
          e_reads++;
        end
        idx++;
      end
      if (!e_to) begin
        e_D += 1;
        e_pass = (e_id == EID) && (!cts || (e_ts == ETS));
      end
    end
    e_D += 1;

    poke_c = poke ? $urandom_range(1, e_D - 2) : 0;
    drive(kick, 1'b0, 32'h0);
    @(posedge clk);
    k = 0; in_txn = 0; stall_left = 0; lat_cnt = 0; addr_err = 0;
    done_c = 0; ts_acc_c = -1; hold = 32'h0; txn_addr = 1'b0;
    for (int c = 1; c <= 3000 && done_c == 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check_eq("busy_rise", 32'(c_busy),  1);
        check_eq("done_clr",  32'(c_done),  0);
        check_eq("match_clr", 32'(c_match), 0);
        check_eq("err_clr",   32'(c_err),   0);
      end
      if (abort && c == ts_acc_c + 1) begin
        set_rst(1'b0);
        #1;
        check_eq("rst_read",  32'(c_read),  0);
        check_eq("rst_addr",  32'(c_addr),  0);
        check_eq("rst_busy",  32'(c_busy),  0);
        check_eq("rst_done",  32'(c_done),  0);
        check_eq("rst_match", 32'(c_match), 0);
        check_eq("rst_err",   32'(c_err),   0);
        check_eq("rst_id",    c_id,         0);
        check_eq("rst_ts",    c_ts,         0);
        m_id[cur] = 32'h0;
        m_ts[cur] = 32'h0;
        drive(1'b0, 1'b0, 32'h0);
        return;
      end
      if (c_done) begin
        done_c = c;
      end else begin
        w = 1'b0;
        d = hold ^ 32'hFFFF_FFFF;
        if (lat_cnt > 0) begin
          lat_cnt--;
          if (lat_cnt == 0) d = hold;
        end
        if (!c_read) begin
          in_txn = 0;
        end else begin
          if (!in_txn) begin
            in_txn     = 1;
            txn_addr   = c_addr;
            stall_left = p_stall[k % 8];
          end else if (c_addr !== txn_addr) begin
            addr_err++;
          end
          if (stall_left > 0) begin
            w = 1'b1;
            stall_left--;
          end else begin
            if (txn_addr !== (k % 2 == 1)) addr_err++;
            hold = p_data[k % 8];
            if (L == 0) d = hold; else lat_cnt = L;
            if (k % 2 == 1) ts_acc_c = c;
            k++;
            in_txn = 0;
          end
        end
        drive(c == poke_c, w, d);
      end
    end
    if (done_c == 0) check_eq("done_seen", 32'(c_done), 1);
    check_eq("done_cycle", done_c,        e_D);
    check_eq("match",      32'(c_match),  32'(e_pass));
    check_eq("timeout",    32'(c_err),    32'(e_to));
    check_eq("id_value",   c_id,          e_id);
    check_eq("ts_value",   c_ts,          e_ts);
    check_eq("reads",      k,             e_reads);
    check_eq("addr_seq",   addr_err,      0);
    check_eq("busy_fall",  32'(c_busy),   0);
    check_eq("read_low",   32'(c_read),   0);
    drive(1'b0, 1'b0, 32'h0);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (c_read || c_busy) extra++;
    end
    check_eq("no_extra",   extra,         0);
    check_eq("done_hold",  32'(c_done),   1);
    check_eq("match_hold", 32'(c_match),  32'(e_pass));
    m_id[cur] = e_id;
    m_ts[cur] = e_ts;
  endtask

  initial begin
    cur = 0;
    rst0_n = 1'b0; rst1_n = 1'b0;
    start0 = 1'b0; wait0 = 1'b0; rdata0 = 32'h0;
    start1 = 1'b0; wait1 = 1'b0; rdata1 = 32'h0;
    m_id[0] = 32'h0; m_ts[0] = 32'h0; m_id[1] = 32'h0; m_ts[1] = 32'h0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      cur = s;
      #1;
      check_eq("reset_read",  32'(c_read),  0);
      check_eq("reset_addr",  32'(c_addr),  0);
      check_eq("reset_busy",  32'(c_busy),  0);
      check_eq("reset_done",  32'(c_done),  0);
      check_eq("reset_match", 32'(c_match), 0);
      check_eq("reset_err",   32'(c_err),   0);
      check_eq("reset_id",    c_id,         0);
      check_eq("reset_ts",    c_ts,         0);
    end
    cur = 0;
    @(negedge clk);
    plan_clean();
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    run_check(1'b0, 1'b0, 1'b0);

    plan_clean();
    p_data[1] = 32'h0; p_data[3] = 32'h0; p_data[5] = 32'h0;
    run_check(1'b1, 1'b0, 1'b0);

    plan_clean();
    for (int i = 0; i < 8; i += 2) p_data[i] = 32'h1234_5678;
    run_check(1'b1, 1'b0, 1'b0);

    plan_clean(); p_stall[0] = T;
    run_check(1'b1, 1'b0, 1'b0);

    plan_clean(); p_stall[0] = T - 1;
    run_check(1'b1, 1'b0, 1'b0);

    plan_clean();
    run_check(1'b1, 1'b1, 1'b0);

    repeat (12) begin
      plan_random(3);
      run_check(1'b1, $urandom_range(0, 1) == 1, 1'b0);
    end

    plan_clean();
    run_check(1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    plan_clean();
    rst0_n = 1'b1;
    run_check(1'b0, 1'b0, 1'b0);

    cur = 1;
    @(negedge clk);
    plan_clean(); p_data[1] = 32'h0;
    run_check(1'b1, 1'b0, 1'b0);

    plan_clean(); p_data[0] = 32'h0BAD_0BAD; p_data[2] = 32'h0BAD_0BAD;
    run_check(1'b1, 1'b0, 1'b0);

    repeat (8) begin
      plan_random(4);
      run_check(1'b1, $urandom_range(0, 1) == 1, 1'b0);
    end

    plan_clean();
    run_check(1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst1_n = 1'b1;
    @(negedge clk);
    plan_clean();
    run_check(1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
